// File: rtl/load_align_unit.sv
// load_align_unit: sequential load path on the read side of the data memory.
// Issues one or two word reads per load, then extracts, merges and extends
// the addressed bytes and returns a tagged one-cycle response.
module load_align_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            load_select,
  input  logic [4:0]            req_rd,
  output logic                  dm_rd,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [31:0]           dm_rdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [4:0]            resp_rd,
  output logic                  resp_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    CAP0 = 3'd2,
    RD1  = 3'd3,
    CAP1 = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [1:0]              off_r, off_s;
  logic [2:0]              sel_r, sel_s;
  logic [4:0]              tag_r, tag_s;
  logic [31:0]             lo_r, lo_s;
  logic                    dm_rd_s;
  logic [ADDR_WIDTH-1:0]   dm_addr_s;
  logic                    resp_valid_s;
  logic                    resp_err_s;
  logic [31:0]             resp_data_s;
  logic [4:0]              resp_rd_s;
  logic                    cross_s;
  logic                    unused_addr_bits_s;

  // Only the word-address bits and the byte offset of req_addr are meaningful.
  assign unused_addr_bits_s = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

  // lb/lh/lw and their unsigned forms; everything else is rejected.
  function automatic logic is_legal(input logic [2:0] sel);
    case (sel)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

  // Shift {hi,lo} down to the addressed byte, then size and extend.
  function automatic logic [31:0] align_load(input logic [31:0] hi,
                                             input logic [31:0] lo,
                                             input logic [1:0]  off,
                                             input logic [2:0]  sel);
    logic [63:0] sh;
    sh = {hi, lo} >> {off, 3'b000};
    case (sel)
      3'b000:  align_load = {{24{sh[7]}}, sh[7:0]};
      3'b100:  align_load = {24'h000000, sh[7:0]};
      3'b001:  align_load = {{16{sh[15]}}, sh[15:0]};
      3'b101:  align_load = {16'h0000, sh[15:0]};
      default: align_load = sh[31:0];
    endcase
  endfunction

  assign req_ready = (state_r == IDLE);

  // A word needs a second read when the access runs past byte 3.
  assign cross_s = ((sel_r[1:0] == 2'b10) && (off_r != 2'b00)) ||
                   ((sel_r[1:0] == 2'b01) && (off_r == 2'b11));

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_s      = state_r;
    off_s        = off_r;
    sel_s        = sel_r;
    tag_s        = tag_r;
    lo_s         = lo_r;
    dm_rd_s      = 1'b0;
    dm_addr_s    = dm_addr;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_data_s  = resp_data;
    resp_rd_s    = resp_rd;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          tag_s = req_rd;
          if (is_legal(load_select)) begin
            off_s     = req_addr[1:0];
            sel_s     = load_select;
            dm_rd_s   = 1'b1;
            dm_addr_s = req_addr[ADDR_WIDTH+1:2];
            state_s   = RD0;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD0: state_s = CAP0;
      CAP0: begin
        if (cross_s) begin
          lo_s      = dm_rdata;
          dm_rd_s   = 1'b1;
          dm_addr_s = dm_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          state_s   = RD1;
        end else begin
          resp_valid_s = 1'b1;
          resp_data_s  = align_load(32'h00000000, dm_rdata, off_r, sel_r);
          resp_rd_s    = tag_r;
          state_s      = IDLE;
        end
      end
      RD1: state_s = CAP1;
      CAP1: begin
        resp_valid_s = 1'b1;
        resp_data_s  = align_load(dm_rdata, lo_r, off_r, sel_r);
        resp_rd_s    = tag_r;
        state_s      = IDLE;
      end
      ERR: begin
        resp_valid_s = 1'b1;
        resp_err_s   = 1'b1;
        resp_data_s  = 32'h00000000;
        resp_rd_s    = tag_r;
        state_s      = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; reset abandons any load in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request context, memory strobe and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_r      <= 2'b00;
      sel_r      <= 3'b000;
      tag_r      <= 5'd0;
      lo_r       <= 32'h00000000;
      dm_rd      <= 1'b0;
      dm_addr    <= {ADDR_WIDTH{1'b0}};
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= 32'h00000000;
      resp_rd    <= 5'd0;
    end else begin
      off_r      <= off_s;
      sel_r      <= sel_s;
      tag_r      <= tag_s;
      lo_r       <= lo_s;
      dm_rd      <= dm_rd_s;
      dm_addr    <= dm_addr_s;
      resp_valid <= resp_valid_s;
      resp_err   <= resp_err_s;
      resp_data  <= resp_data_s;
      resp_rd    <= resp_rd_s;
    end
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Sequential load-data unit on the read side of the data memory, mirroring the store path's byte-lane formatting. It accepts one load request at a time and issues word reads to the 1-cycle-latency data memory. Misaligned accesses that cross a word boundary are split into two reads. The unit then extracts, merges and sign- or zero-extends the addressed bytes and returns the result with a tagged one-cycle valid pulse for writeback.

## Interface
- ADDR_WIDTH, 12, width of the data-memory word address (`dm_addr`).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request; equals (state == IDLE).
- req_addr  input  32  byte address.
- load_select  input  3  RISC-V funct3: lb=0, lh=1, lw=2, lbu=4, lhu=5; 3, 6 and 7 are illegal.
- req_rd  input  5  destination register tag, returned unchanged.
- dm_rd  output  1  memory read strobe (registered).
- dm_addr  output  ADDR_WIDTH  word address, `req_addr[ADDR_WIDTH+1:2]` (+1 for the second read), registered.
- dm_rdata  input  32  memory read word, valid in the cycle after the edge that sampled `dm_rd`. Byte at offset k sits in bits [8k+7:8k]. This is the same lane order the store path writes.
- resp_valid  output  1  one-cycle result pulse.
- resp_data  output  32  extended load result.
- resp_rd  output  5  tag of the completed load.
- resp_err  output  1  illegal `load_select`; valid with `resp_valid`.

## Operation
- States: IDLE, RD0, CAP0, RD1, CAP1, ERR.
- IDLE: `req_ready`=1.
  - On `req_valid` with a legal select, latch addr[1:0], select and tag. Set `dm_rd`<=1 and `dm_addr`<=word address, then go to RD0.
  - On `req_valid` with an illegal select, latch the tag and go to ERR. No memory access is made.
- RD0: `dm_rd`<=0, then go to CAP0. Memory samples the read on this edge.
- CAP0: `dm_rdata` holds the low word.
  - Crossing case: latch the low word, set `dm_rd`<=1 and `dm_addr`<=word+1 (modulo 2^ADDR_WIDTH), then go to RD1.
  - Otherwise: produce the result and go to IDLE.
- RD1: `dm_rd`<=0, then go to CAP1.
- CAP1: merge the high word, produce the result, then go to IDLE.
- ERR: `resp_valid`<=1, `resp_err`<=1, `resp_data`<=0, then go to IDLE.
- Crossing condition: lw with offset≠0, or lh/lhu with offset 3. lb never crosses.
- Extraction:
  - Form the 64-bit value {hi, lo}, with hi=0 when there is no crossing.
  - Shift right by 8×offset and take bits [31:0].
  - lb: sign-extend [7:0]. lbu: zero-extend [7:0].
  - lh: sign-extend [15:0]. lhu: zero-extend [15:0].
  - lw: pass unchanged.
- `resp_valid` and `resp_err` are registered. They are high for exactly one cycle, then cleared.
- `resp_data` and `resp_rd` hold their values until the next response.
- A new request may be accepted in the same cycle that `resp_valid` is high, because the state is IDLE.
- `req_*` inputs are ignored when `req_ready`=0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `dm_rd`=0, `dm_addr`=0, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `resp_err`=0.
- `rst` overrides all transitions. Reset mid-operation abandons the load: no `resp_valid` is produced and any in-flight `dm_rdata` is ignored.
- Latency is counted from accept edge E0:
  - Aligned or non-crossing load: `resp_valid` high after E2, one request per 3 cycles.
  - Crossing load: second `dm_rd` high after E2, `resp_valid` high after E4.
  - Illegal select: `resp_valid` high after E1.
- `dm_rd` is never high for two consecutive cycles.

## Test plan
- Setup: memory word 0x40=0x44332211, 0x41=0x88776655, 0x42=0xCCBBAA99.
- lb 0x107 -> resp_data 0xFFFFFF88; lbu 0x107 -> 0x00000088; each uses a single `dm_rd` at 0x41 and `resp_valid` after E2.
- lh 0x101 -> 0x00003322 with no second read. lh 0x107 -> reads 0x41 then 0x42, result 0xFFFF9988. lhu 0x107 -> 0x00009988.
- lw 0x100 -> 0x44332211 after E2. lw 0x102 -> reads 0x40 then 0x41, result 0x66554433 after E4, `resp_rd` equals the request tag.
- Wrap-around: lw at byte 0x3FFE with ADDR_WIDTH=12 -> `dm_addr` 0xFFF then 0x000, merged correctly.
- Illegal select 3 with tag 7 -> `resp_valid`=1, `resp_err`=1, `resp_data`=0, `resp_rd`=7 after E1, and `dm_rd` stays 0.
- Reset mid-load: assert `rst` in RD1 -> next cycle `dm_rd`=0, `req_ready`=1, and no `resp_valid` ever appears. A subsequent lw 0x100 returns 0x44332211.
